fpmul_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined FPmul (IEEE-754 single precision, fixed latency, no stall input) among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready, issues at most one multiply per cycle and tags each issue with its requester ID.
- Delivers results, with their tags, in issue order through a result FIFO behind an out valid/ready port.
- Credit accounting guarantees the non-stallable multiplier never overflows the FIFO.

---
 rtl/fpmul_sched_pkg.sv | 40 ++++
 rtl/sched_fifo.sv | 59 +++++
 rtl/fpmul_sched.sv | 115 +++++++++++
 tb/tb_fpmul_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_sched_pkg.sv
// Shared types for the FPmul scheduler: fp32 word, tagged result and the round-robin pick helper.
// Tags are sized for the largest supported requester count; the top truncates to its own ID_W.
package fpmul_sched_pkg;

  localparam int MAX_REQ = 8;
  localparam int TAG_W   = 3;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t            data;
    logic [TAG_W-1:0] id;
  } res_t;

  typedef struct packed {
    logic             found;
    logic [TAG_W-1:0] idx;
  } pick_t;

  // First valid requester strictly after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [TAG_W-1:0]   ptr,
                                    input int                 n);
    pick_t            p;
    int               c;
    logic [TAG_W-1:0] ci;
    p.found = 1'b0;
    p.idx   = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      c  = (int'(ptr) + k) % n;
      ci = TAG_W'(c);
      if (k <= n && !p.found && valid[ci]) begin
        p.found = 1'b1;
        p.idx   = ci;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// First-word-fall-through result FIFO with registered storage and an occupancy count.
// Simultaneous push and pop is legal at any fill level; pushing into a full FIFO without a pop is an error.
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && (cnt != '0);
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !do_pop && cnt == CNT_W'(DEPTH)))
        else $error("sched_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/fpmul_sched.sv
// Round-robin share of one fixed-latency FPmul; results leave in issue order through a FWFT FIFO.
// Issue needs a credit (FIFO entries + products in flight < depth), so the unstallable multiplier never overflows.
module fpmul_sched
  import fpmul_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [ID_W-1:0]      out_id
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

  generate
    if (FIFO_DEPTH < MUL_LAT + 1) begin : g_depth_chk
      $error("fpmul_sched: FIFO_DEPTH must be >= MUL_LAT+1");
    end
    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_nreq_chk
      $error("fpmul_sched: N_REQ must be in 2..8");
    end
  endgenerate

  logic [ID_W-1:0]   ptr;
  logic [MUL_LAT-1:0] vld_pipe;
  logic [ID_W-1:0]   id_pipe [MUL_LAT];
  logic [CRED_W-1:0] inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              can_issue;
  logic              issue;
  logic [ID_W-1:0]   win;
  pick_t             pick;
  res_t              push_res;
  res_t              head;
  logic [$bits(res_t)-1:0] head_bits;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < MUL_LAT; k++) inflight = inflight + CRED_W'(vld_pipe[k]);
  end

  // A pop in this cycle only frees its credit once fifo_count updates.
  assign can_issue = (CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEPTH);
  assign pick      = rr_pick(MAX_REQ'(req_valid), TAG_W'(ptr), N_REQ);
  assign issue     = !rst && can_issue && pick.found;
  assign win       = pick.idx[ID_W-1:0];

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (issue && win == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[32*i +: 32];
        mul_b        = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= ID_W'(N_REQ - 1);
      vld_pipe <= '0;
      for (int k = 0; k < MUL_LAT; k++) id_pipe[k] <= '0;
    end else begin
      vld_pipe[0] <= issue;
      id_pipe[0]  <= issue ? win : '0;
      for (int k = 1; k < MUL_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      if (issue) ptr <= win;
    end
  end

  always_comb begin
    push_res      = '0;
    push_res.data = mul_z;
    push_res.id   = TAG_W'(id_pipe[MUL_LAT-1]);
  end

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(res_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[MUL_LAT-1]),
    .push_data (push_res),
    .pop       (out_valid && out_ready),
    .pop_data  (head_bits),
    .count     (fifo_count)
  );

  assign head      = res_t'(head_bits);
  assign out_valid = (fifo_count != '0);
  assign out_data  = head.data;
  assign out_id    = head.id[ID_W-1:0];

endmodule

// File: tb/tb_fpmul_sched.sv
// Bench for fpmul_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_fpmul_sched;

  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a, req_b;
  logic [31:0]       mul_a, mul_b, mul_z;
  logic              out_valid, out_ready;
  logic [31:0]       out_data;
  logic [IDW-1:0]    out_id;

  always #5 clk = ~clk;

  fpmul_sched #(.N_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) return {a[31] ^ b[31], 8'(e + 10'd1), p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  // Exact conversion of small positive integers to single precision.
  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] vv, m;
    int          p;
    vv = 32'(v);
    if (vv == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (vv[i]) p = i;
    m = vv << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Multiplier stand-in with LAT-cycle latency; never reset, so stale products keep emerging.
  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_z = mpipe[LAT-1];

  typedef struct {
    logic [31:0] d;
    int          id;
    int          vis;
  } exp_t;

  exp_t        q[$];
  int          aval[N], bval[N];
  int          mptr, outstanding, cyc;
  int          checks, failures;
  logic [N-1:0] seen_rdy;
  logic        seen_pop;
  logic [31:0] seen_pop_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive operands, compare outputs at negedge against the model, advance the model.
  task automatic step();
    int          win;
    logic [N-1:0] exp_rdy;
    logic [31:0] ea, eb;
    logic        exp_vld, pop;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = int_to_fp(aval[i]);
      req_b[32*i +: 32] = int_to_fp(bval[i]);
    end
    @(negedge clk);
    win = -1; exp_rdy = '0; ea = '0; eb = '0;
    if (!rst && outstanding < DEPTH)
      for (int k = 1; k <= N; k++)
        if (win < 0 && req_valid[(mptr + k) % N]) win = (mptr + k) % N;
    if (win >= 0) begin
      exp_rdy[win] = 1'b1;
      ea = int_to_fp(aval[win]);
      eb = int_to_fp(bval[win]);
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("mul_a", mul_a, ea);
    check("mul_b", mul_b, eb);
    seen_rdy = req_ready;
    exp_vld  = 1'b0;
    pop      = 1'b0;
    if (!rst) begin
      exp_vld = (q.size() > 0) && (q[0].vis <= cyc);
      check("out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld) begin
        check("out_data", out_data, q[0].d);
        check("out_id", 32'(out_id), 32'(q[0].id));
      end
      pop = exp_vld && out_ready;
    end
    seen_pop   = pop;
    seen_pop_d = out_data;
    @(posedge clk);
    if (rst) begin
      q.delete();
      outstanding = 0;
      mptr = N - 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (win >= 0) begin
        q.push_back('{d: int_to_fp(aval[win] * bval[win]), id: win, vis: cyc + LAT + 1});
        mptr = win;
      end
      outstanding = outstanding + ((win >= 0) ? 1 : 0) - (pop ? 1 : 0);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) step();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) step();
    check("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] fair_d [4];
    int issues, ci, pops;
    fair_d[0] = 32'h40000000; fair_d[1] = 32'h40800000;
    fair_d[2] = 32'h40C00000; fair_d[3] = 32'h41000000;
    checks = 0; failures = 0; cyc = 0; mptr = N - 1; outstanding = 0;
    req_valid = '0; out_ready = 1'b1; rst = 1'b1;
    for (int i = 0; i < N; i++) begin aval[i] = i + 1; bval[i] = 2; end

    // Reset state
    do_reset(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single multiply 2.0 * 3.0
    aval[0] = 2; bval[0] = 3; req_valid = 4'b0001;
    ci = cyc;
    step();
    check("single_grant", 32'(seen_rdy), 32'h1);
    req_valid = '0;
    for (int k = 0; k < 10 && !out_valid; k++) step();
    check("single_latency", 32'(cyc - ci), 32'(LAT + 1));
    check("single_data", out_data, 32'h40C00000);
    check("single_id", 32'(out_id), 32'd0);
    drain();

    // Fairness: all valid, grants rotate from requester 0
    do_reset(1);
    for (int i = 0; i < N; i++) begin aval[i] = i + 1; bval[i] = 2; end
    req_valid = 4'b1111;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_grant", 32'(seen_rdy), 32'(1 << (k % 4)));
      if (seen_pop) begin check("fair_data", seen_pop_d, fair_d[pops % 4]); pops++; end
    end
    req_valid = '0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      step();
      if (seen_pop) begin check("fair_data", seen_pop_d, fair_d[pops % 4]); pops++; end
    end
    check("fair_pops", 32'(pops), 32'd8);

    // Backpressure: exactly DEPTH issues, then stall until the consumer drains
    do_reset(1);
    out_ready = 1'b0; req_valid = 4'b0011;
    issues = 0;
    for (int k = 0; k < 10; k++) begin step(); if (seen_rdy != '0) issues++; end
    check("bp_issues", 32'(issues), 32'(DEPTH));
    check("bp_stalled", 32'(seen_rdy), 32'd0);
    check("bp_full_valid", 32'(out_valid), 32'd1);
    // Single-cycle pop while full, then resume draining with issue continuing
    out_ready = 1'b1; step();
    out_ready = 1'b0; for (int k = 0; k < 4; k++) step();
    out_ready = 1'b1; for (int k = 0; k < 12; k++) step();
    drain();

    // Reset with one product in the FIFO and two in flight
    do_reset(1);
    out_ready = 1'b0;
    aval[1] = 3; aval[2] = 5; aval[3] = 9;
    req_valid = 4'b0010; step();
    req_valid = 4'b0000; step();
    req_valid = 4'b0100; step();
    req_valid = 4'b1000; step();
    req_valid = 4'b0000;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset(1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post_rst_empty", 32'(out_valid), 32'd0);
    end
    aval[2] = 7; bval[2] = 5; req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int k = 0; k < 10 && !out_valid; k++) step();
    check("post_rst_data", out_data, 32'h420C0000);
    check("post_rst_id", 32'(out_id), 32'd2);
    drain();

    // Sparse requesters and pointer wrap
    do_reset(1);
    out_ready = 1'b1; aval[3] = 11; bval[3] = 13; aval[0] = 17; bval[0] = 19;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) check("sparse_r3", 32'(seen_rdy), 32'h8);
    end
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) check("sparse_r0", 32'(seen_rdy), 32'h1);
    end
    drain();

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        aval[i] = $urandom_range(1, 255);
        bval[i] = $urandom_range(1, 255);
      end
      step();
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
